// File: rtl/a_ctrls_slew_if.sv
// Control-word bundle between the control decoder and the slew limiter.
// Master drives targets and bypass; slave returns slewed values and status.
interface a_ctrls_slew_if #(
  parameter int BITS = 8,
  parameter int NCH  = 7
);
  logic [NCH*BITS-1:0] values_in;
  logic                bypass;
  logic [NCH*BITS-1:0] values_out;
  logic                busy;
  logic                settled;

  modport master (
    output values_in, bypass,
    input  values_out, busy, settled
  );

  modport slave (
    input  values_in, bypass,
    output values_out, busy, settled
  );
endinterface

// File: rtl/a_ctrls_slew.sv
// Per-channel slew-rate limiter for the packed control word.
// One shared add/compare datapath is time-multiplexed over the channels.
module a_ctrls_slew #(
  parameter int FCLK = 50_000_000,
  parameter int FUPD = 1_000,
  parameter int BITS = 8,
  parameter int NCH  = 7,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  a_ctrls_slew_if.slave io
);

  localparam int DIV = FCLK / FUPD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = BITS + 1;

  if (DIV < NCH + 1) begin : g_div_chk
    $error("a_ctrls_slew: DIV must be at least NCH+1");
  end
  if (STEP < 1 || STEP > (2**BITS) - 1) begin : g_step_chk
    $error("a_ctrls_slew: STEP out of range");
  end

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [NCH*BITS-1:0] out_q;
  logic                busy_q;
  logic                settled_q;

  logic                tick;
  logic [BITS-1:0]     cur;
  logic [BITS-1:0]     tgt;
  logic [AW-1:0]       cur_w;
  logic [AW-1:0]       tgt_w;
  logic [AW-1:0]       diff;
  logic [AW-1:0]       delta;
  logic [AW-1:0]       nxt_w;
  logic [BITS-1:0]     nxt;
  logic                up;
  logic                dn;

  localparam logic [AW-1:0] STEP_W = AW'(STEP);

  assign tick = (cnt == CW'(DIV - 1));
  assign cur  = out_q[idx*BITS +: BITS];
  assign tgt  = io.values_in[idx*BITS +: BITS];

  always_comb begin
    cur_w = {1'b0, cur};
    tgt_w = {1'b0, tgt};
    up    = (tgt_w > cur_w);
    dn    = (tgt_w < cur_w);
    diff  = '0;
    delta = '0;
    nxt_w = cur_w;
    unique case (1'b1)
      up: begin
        diff  = tgt_w - cur_w;
        delta = (diff < STEP_W) ? diff : STEP_W;
        nxt_w = cur_w + delta;
      end
      dn: begin
        diff  = cur_w - tgt_w;
        delta = (diff < STEP_W) ? diff : STEP_W;
        nxt_w = cur_w - delta;
      end
      default: nxt_w = cur_w;
    endcase
    // A carry/borrow would mean wrap-around; pin to the rail instead
    if (nxt_w[BITS])
      nxt = up ? '1 : '0;
    else
      nxt = nxt_w[BITS-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      settled_q <= (out_q == io.values_in);
      if (io.bypass) begin
        out_q  <= io.values_in;
        state  <= IDLE;
        cnt    <= '0;
        idx    <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt <= tick ? '0 : cnt + CW'(1);
        unique case (state)
          IDLE: begin
            if (tick) begin
              state  <= SCAN;
              busy_q <= 1'b1;
              idx    <= '0;
            end
          end
          SCAN: begin
            out_q[idx*BITS +: BITS] <= nxt;
            if (idx == IW'(NCH - 1)) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              idx    <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io.values_out = out_q;
  assign io.busy       = busy_q;
  assign io.settled    = settled_q;

endmodule

// File: tb/tb_a_ctrls_slew.sv
// Bench for a_ctrls_slew: STEP=1 and STEP=4 instances, directed table,
// hand sequences and randomized traffic against a tick/visit reference model.
module tb_a_ctrls_slew;

  localparam int BITS = 8;
  localparam int NCH  = 7;
  localparam int DIV  = 10;
  localparam int W    = NCH * BITS;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  a_ctrls_slew_if #(.BITS(BITS), .NCH(NCH)) if1 ();
  a_ctrls_slew_if #(.BITS(BITS), .NCH(NCH)) if4 ();

  a_ctrls_slew #(
    .FCLK(1000), .FUPD(100), .BITS(BITS), .NCH(NCH), .STEP(1)
  ) u1 (
    .clk(clk), .reset(reset), .io(if1.slave)
  );

  a_ctrls_slew #(
    .FCLK(1000), .FUPD(100), .BITS(BITS), .NCH(NCH), .STEP(4)
  ) u4 (
    .clk(clk), .reset(reset), .io(if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  // Reference model: edges since start (or bypass release), tick every
  // DIV edges, channel k visited k+1 edges after the tick.
  logic [7:0] m_out [2][NCH];
  int         m_n   [2];
  int         m_pos [2];
  bit         m_set [2];

  function automatic logic [7:0] toward(int c, int t, int s);
    int d;
    if (t > c) begin
      d = (t - c < s) ? t - c : s;
      return 8'(c + d);
    end else if (t < c) begin
      d = (c - t < s) ? c - t : s;
      return 8'(c - d);
    end
    return 8'(c);
  endfunction

  function automatic logic [W-1:0] vin_of(int d);
    return (d == 0) ? if1.values_in : if4.values_in;
  endfunction

  function automatic bit byp_of(int d);
    return (d == 0) ? if1.bypass : if4.bypass;
  endfunction

  function automatic bit busy_of(int d);
    return (d == 0) ? if1.busy : if4.busy;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < NCH; k++) m_out[d][k] <= 8'h00;
        m_n[d]   <= 0;
        m_pos[d] <= -1;
        m_set[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [W-1:0] v;
        logic [7:0]   o [NCH];
        bit           s;
        int           n;
        int           p;
        v = vin_of(d);
        s = 1'b1;
        for (int k = 0; k < NCH; k++) begin
          o[k] = m_out[d][k];
          if (o[k] != v[k*8 +: 8]) s = 1'b0;
        end
        if (byp_of(d)) begin
          for (int k = 0; k < NCH; k++) o[k] = v[k*8 +: 8];
          n = 0;
          p = -1;
        end else begin
          n = m_n[d] + 1;
          p = m_pos[d];
          if (p >= 0) begin
            o[p] = toward(o[p], v[p*8 +: 8], (d == 0) ? 1 : 4);
            p++;
            if (p == NCH) p = -1;
          end
          if (n % DIV == 0) p = 0;
        end
        for (int k = 0; k < NCH; k++) m_out[d][k] <= o[k];
        m_n[d]   <= n;
        m_pos[d] <= p;
        m_set[d] <= s;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [W-1:0] ev;
      for (int k = 0; k < NCH; k++) ev[k*8 +: 8] = m_out[d][k];
      if (d == 0) begin
        chk("m1_values", 64'(if1.values_out), 64'(ev));
        chk("m1_busy", 64'(if1.busy), 64'(m_pos[0] >= 0));
        chk("m1_settled", 64'(if1.settled), 64'(m_set[0]));
      end else begin
        chk("m4_values", 64'(if4.values_out), 64'(ev));
        chk("m4_busy", 64'(if4.busy), 64'(m_pos[1] >= 0));
        chk("m4_settled", 64'(if4.settled), 64'(m_set[1]));
      end
    end
  end

  task automatic wait_scan(int d);
    int c;
    c = 0;
    while (!busy_of(d) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    while (busy_of(d) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c >= 100) begin
      errors++;
      $display("FAIL scan_timeout actual %0d required <100", c);
    end
  endtask

  task automatic set_tgt(int d, int ch, logic [7:0] t);
    if (d == 0) if1.values_in[ch*8 +: 8] = t;
    else        if4.values_in[ch*8 +: 8] = t;
  endtask

  function automatic logic [7:0] ch_of(int d, int ch);
    return (d == 0) ? if1.values_out[ch*8 +: 8] : if4.values_out[ch*8 +: 8];
  endfunction

  typedef struct {
    int         sel;
    int         ch;
    logic [7:0] tgt;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [7:0] pick [7];
    int c;
    checks = 0;
    errors = 0;

    vt[0] = '{0, 0, 8'h05, 8'h01};
    vt[1] = '{0, 0, 8'h05, 8'h02};
    vt[2] = '{0, 0, 8'h05, 8'h03};
    vt[3] = '{0, 0, 8'h05, 8'h04};
    vt[4] = '{0, 0, 8'h05, 8'h05};
    vt[5] = '{1, 2, 8'h06, 8'h04};
    vt[6] = '{1, 2, 8'h06, 8'h06};
    vt[7] = '{1, 2, 8'h01, 8'h02};
    vt[8] = '{1, 2, 8'h01, 8'h01};

    reset = 1'b1;
    if1.values_in = '0;
    if1.bypass    = 1'b0;
    if4.values_in = '0;
    if4.bypass    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(posedge clk); #1;
    chk("rst_values", 64'(if1.values_out), 64'h0);
    chk("rst_busy", 64'(if1.busy), 64'h0);
    chk("rst_settled", 64'(if1.settled), 64'h1);
    chk("rst_settled4", 64'(if4.settled), 64'h1);

    for (int i = 0; i < 9; i++) begin
      set_tgt(vt[i].sel, vt[i].ch, vt[i].tgt);
      wait_scan(vt[i].sel);
      chk($sformatf("vec%0d", i), 64'(ch_of(vt[i].sel, vt[i].ch)), 64'(vt[i].exp));
      if (i == 4) begin
        chk("step1_settled", 64'(if1.settled), 64'h1);
        chk("step1_others", 64'(if1.values_out[W-1:8]), 64'h0);
      end
    end

    if4.values_in[6*8 +: 8] = 8'hFD;
    if4.bypass = 1'b1;
    @(posedge clk); #1;
    if4.bypass = 1'b0;
    chk("pre_fd", 64'(ch_of(1, 6)), 64'hFD);
    set_tgt(1, 6, 8'hFF);
    wait_scan(1);
    chk("top_clamp", 64'(ch_of(1, 6)), 64'hFF);
    if4.values_in[6*8 +: 8] = 8'h02;
    if4.bypass = 1'b1;
    @(posedge clk); #1;
    if4.bypass = 1'b0;
    set_tgt(1, 6, 8'h00);
    wait_scan(1);
    chk("bot_clamp", 64'(ch_of(1, 6)), 64'h00);

    if1.values_in = {NCH{8'hAA}};
    if1.bypass = 1'b1;
    @(posedge clk); #1;
    chk("byp_values", 64'(if1.values_out), 64'({NCH{8'hAA}}));
    chk("byp_busy", 64'(if1.busy), 64'h0);
    @(posedge clk); #1;
    chk("byp_settled", 64'(if1.settled), 64'h1);
    repeat (3) @(posedge clk);
    #1 if1.bypass = 1'b0;
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!if1.busy && c < 50);
    chk("byp_tick_delay", 64'(c), 64'd10);

    if1.values_in = {NCH{8'h30}};
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_values", 64'(if1.values_out), 64'h0);
    chk("arst_busy", 64'(if1.busy), 64'h0);
    chk("arst_values4", 64'(if4.values_out), 64'h0);
    @(posedge clk); #1 reset = 1'b0;
    wait_scan(0);
    chk("ramp_restart", 64'(if1.values_out), 64'({NCH{8'h01}}));

    pick[0] = 8'h00; pick[1] = 8'h01; pick[2] = 8'h02;
    pick[3] = 8'hFD; pick[4] = 8'hFE; pick[5] = 8'hFF;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(7) == 0) begin
          pick[6] = 8'($urandom);
          set_tgt(d, $urandom_range(NCH - 1), pick[$urandom_range(6)]);
        end
        if (d == 0) if1.bypass = ($urandom_range(150) == 0);
        else        if4.bypass = ($urandom_range(150) == 0);
      end
    end
    if1.bypass = 1'b0;
    if4.bypass = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
